// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes driven to the ALU, main-control ALUOp
// values, the R-format opcodes this stage understands, and the decode helper.
package alu_pkg;

    // 4-bit ALU control codes (the ALU decodes these same values)
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_BAD   = 4'b1111;

    // Main-control ALUOp values
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // R-format opcodes, instruction[31:21]
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    // Result of the ALU control decode
    typedef struct packed {
        logic [3:0] ctrl;
        logic       illegal;
    } alu_decode_t;

    // Maps ALUOp plus opcode onto an ALU control code; anything undecodable
    // becomes ALU_BAD with the illegal flag set.
    function automatic alu_decode_t decode_alu(input logic [1:0]  alu_op,
                                               input logic [10:0] opcode);
        alu_decode_t d;
        d.ctrl    = ALU_BAD;
        d.illegal = 1'b1;
        case (alu_op)
            ALUOP_MEM: begin
                d.ctrl    = ALU_ADD;
                d.illegal = 1'b0;
            end
            ALUOP_CBZ: begin
                d.ctrl    = ALU_PASSB;
                d.illegal = 1'b0;
            end
            ALUOP_RTYPE: begin
                case (opcode)
                    OPC_ADD: begin d.ctrl = ALU_ADD; d.illegal = 1'b0; end
                    OPC_SUB: begin d.ctrl = ALU_SUB; d.illegal = 1'b0; end
                    OPC_AND: begin d.ctrl = ALU_AND; d.illegal = 1'b0; end
                    OPC_ORR: begin d.ctrl = ALU_ORR; d.illegal = 1'b0; end
                    default: begin d.ctrl = ALU_BAD; d.illegal = 1'b1; end
                endcase
            end
            default: begin
                d.ctrl    = ALU_BAD;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// LEGv8 register file: two read ports, one write port. The top index is XZR,
// which reads as zero and swallows writes. A write in flight is forwarded to
// any read port addressing the same register so the reader never sees stale data.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != XZR);

    // Storage update: synchronous clear of every register, otherwise one write per edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports with XZR forced to zero and same-cycle write forwarding
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_a == XZR) begin
            rd_data_a = '0;
        end else if (wr_live && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (rd_addr_b == XZR) begin
            rd_data_b = '0;
        end else if (wr_live && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage feeding the 64-bit ALU: reads the register file, picks
// the second operand, decodes the ALU control code and hands everything to
// the ALU through a single valid/ready output register.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rn,
    input  logic [ADDR_W-1:0] rm,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [1:0]        alu_op,
    input  logic [10:0]       opcode,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [3:0]        alu_ctrl,
    output logic              illegal
);

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] op_b_next;
    alu_decode_t       dec;
    logic              accept;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rn),
        .rd_data_a (rd_a),
        .rd_addr_b (rm),
        .rd_data_b (rd_b),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // The register is free when empty or being drained this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Second-operand select and control decode for the instruction on the inputs
    always_comb begin
        op_b_next = use_imm ? imm : rd_b;
        dec       = decode_alu(alu_op, opcode);
    end

    // Output register: load on accept, drop valid when drained, hold while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            alu_ctrl  <= ALU_AND;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op_a      <= rd_a;
            op_b      <= op_b_next;
            alu_ctrl  <= dec.ctrl;
            illegal   <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch / ID-EX stage directly upstream of the 64-bit ALU.
- Holds the 32x64 LEGv8 register file and decodes main-control ALUOp plus the opcode field into the 4-bit ALU control code.
- Presents registered operands I1/I2 and the ALU control code to the ALU through a one-entry valid/ready pipeline register.
- Accepts one writeback per cycle from the downstream stage.

Parameters:
- DATA_W, 64, operand/register width
- NREGS, 32, architectural register count; index NREGS-1 (X31) is XZR
- ADDR_W, 5, register index width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  decoded instruction fields present
- in_ready  output  1  stage can accept this cycle
- rn  input  ADDR_W  first source register
- rm  input  ADDR_W  second source register
- imm  input  DATA_W  sign-extended immediate
- use_imm  input  1  1: op_b = imm, else op_b = R[rm]
- alu_op  input  2  main-control ALUOp
- opcode  input  11  instruction[31:21]
- wb_en  input  1  register write enable
- wb_addr  input  ADDR_W  write index
- wb_data  input  DATA_W  write data
- out_valid  output  1  op_a/op_b/alu_ctrl valid for ALU
- out_ready  input  1  ALU/EX consumes this cycle
- op_a  output  DATA_W  ALU I1
- op_b  output  DATA_W  ALU I2
- alu_ctrl  output  4  ALU ALUcontrol
- illegal  output  1  registered with outputs; opcode not decodable

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0; op_a=0; op_b=0; alu_ctrl=4'b0000; illegal=0; all 32 registers cleared to 0. Reset overrides every other event in the same cycle, including wb_en and in_valid.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. Outputs load on the next edge, out_valid=1: latency 1 cycle.
  - If out_ready && !(in_valid && in_ready) then out_valid drops to 0.
  - While out_valid && !out_ready, op_a/op_b/alu_ctrl/illegal hold bit-exact and nothing is accepted.
- Register file:
  - Write on the edge when wb_en=1; wb_addr=31 is ignored.
  - Reads of index 31 return 0.
  - Same-cycle wb_en with wb_addr==rn or rm (≠31) bypasses: the accepted operand is wb_data, not the stale value.
  - Operands are sampled at accept; writes during a stall do not alter held outputs.
- ALU control decode (registered into alu_ctrl):
  - ALUOp 00 -> 0010 (add, loads/stores)
  - ALUOp 01 -> 0111 (pass B, CBZ)
  - ALUOp 10 + opcode:
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
    - any other opcode -> 1111 with illegal=1
  - ALUOp 11 -> 1111, illegal=1.
  - Illegal does not block the pipeline.
- op_b mux: use_imm selects imm unmodified (no extension inside this block).

Decomposition:
- Shared package alu_pkg: ALU control code constants (ALU_AND=0000, ALU_ORR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASSB=0111, ALU_BAD=1111), ALUOp constants, and the four R-format opcode constants. The ALU itself reuses these codes.
- One sub-module alu_regfile: 2 read ports, 1 write port, XZR handling, write bypass, synchronous clear.
- Decode and handshake stay in the top.

Test Plan:
- Reset: hold rst_n=0 two cycles with wb_en=1, in_valid=1 -> out_valid=0, all outputs 0, no register written (read X1 afterwards = 0).
- ADD: write X1=1915, X2=1402. Issue rn=1, rm=2, alu_op=10, opcode=10001011000 -> next cycle out_valid=1, op_a=1915, op_b=1402, alu_ctrl=0010.
- AND with bypass: same cycle as issue, wb X3=24411 and X4=51414 is not possible (one write port). Instead, write X3=24411 the prior cycle and write X4=51414 in the issue cycle of rn=3, rm=4, opcode AND -> op_a=24411, op_b=51414 (bypassed), alu_ctrl=0000.
- XZR/immediate: write X31=99, then issue rn=31, use_imm=1, imm=-8, alu_op=00 -> op_a=0, op_b=64'hFFFF_FFFF_FFFF_FFF8, alu_ctrl=0010.
- Backpressure: out_ready=0 for 3 cycles with a new in_valid pending -> in_ready=0, outputs unchanged. Raise out_ready -> pending instruction loaded next cycle, no loss or duplication.
- Illegal: alu_op=10, opcode=11111111111 -> alu_ctrl=1111, illegal=1, out_valid=1. Next legal SUB -> alu_ctrl=0110, illegal=0.
